// File: rtl/afx_frame_arbiter.sv
// Round-robin frame arbiter: grants one requester at a time for a whole frame,
// forwards its beats into a shared skid buffer and force-releases stalled owners.
module afx_frame_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int TMO  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              buf_push,
  output logic [DW:0]       buf_din,
  input  logic              buf_full,
  input  logic              buf_afull,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_len,
  output logic              tmo_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] rr_ptr, owner, pick, next_rr;
  logic          pick_vld;
  logic [15:0]   beat_cnt, stall_cnt;
  logic          own_valid, own_last, room, beat, last_beat, timeout;
  logic [DW-1:0] own_data;

  // Scan offsets from high to low so the nearest valid requester past rr_ptr wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx]) begin
        pick     = PW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // grant is all-zero in IDLE, so the owner mux yields zeros there.
  always_comb begin
    own_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) own_data = own_data | req_data[i*DW +: DW];
  end

  assign own_valid = |(req_valid & grant);
  assign own_last  = |(req_last & grant);
  assign room      = ~buf_afull & ~buf_full;
  assign req_ready = grant & {NREQ{room}};
  assign beat      = own_valid & room;
  assign buf_push  = beat;
  assign buf_din   = {own_last, own_data};
  assign busy      = (state == XFER);
  assign last_beat = beat & own_last;
  assign timeout   = busy & ~own_valid & (stall_cnt == 16'(TMO - 1));
  assign next_rr   = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = XFER;
      XFER:    if (last_beat || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= '0;
      owner      <= '0;
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      stall_cnt  <= '0;
      frame_len  <= '0;
      frame_done <= 1'b0;
      tmo_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      tmo_err    <= 1'b0;
      if (state == IDLE) begin
        if (pick_vld) begin
          grant     <= NREQ'(1) << pick;
          owner     <= pick;
          beat_cnt  <= '0;
          stall_cnt <= '0;
        end
      end else if (last_beat) begin
        grant      <= '0;
        frame_done <= 1'b1;
        frame_len  <= (beat_cnt == 16'hFFFF) ? beat_cnt : beat_cnt + 16'd1;
        rr_ptr     <= next_rr;
      end else if (timeout) begin
        grant     <= '0;
        tmo_err   <= 1'b1;
        frame_len <= beat_cnt;
        rr_ptr    <= next_rr;
      end else if (beat) begin
        beat_cnt  <= (beat_cnt == 16'hFFFF) ? beat_cnt : beat_cnt + 16'd1;
        stall_cnt <= '0;
      end else if (!own_valid) begin
        // Buffer backpressure alone never ages the owner toward timeout.
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_afx_frame_arbiter.sv
// Directed bench for afx_frame_arbiter: single frame, round-robin, backpressure,
// timeout, non-owner isolation and mid-frame reset, with hand-computed expectations.
module tb_afx_frame_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TMO  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_last, req_ready, grant;
  logic [NREQ*DW-1:0] req_data;
  logic              buf_push, buf_full, buf_afull, busy, frame_done, tmo_err;
  logic [DW:0]       buf_din;
  logic [15:0]       frame_len;

  int checks = 0;
  int errors = 0;

  afx_frame_arbiter #(.NREQ(NREQ), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .buf_push(buf_push),
    .buf_din(buf_din), .buf_full(buf_full), .buf_afull(buf_afull),
    .grant(grant), .busy(busy), .frame_done(frame_done),
    .frame_len(frame_len), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_exp [5];
    rr_exp = '{3, 0, 1, 2, 3};
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
    buf_full = 1'b0; buf_afull = 1'b0;
    tick(); tick();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flen", frame_len, 0);
    chk("rst_fdone", frame_done, 0);
    chk("rst_tmo", tmo_err, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_push", buf_push, 0);
    rst = 1'b0;
    tick();

    // single requester, 3-beat frame
    req_valid = 4'b0100; req_data[2*DW +: DW] = 8'hA0; #1;
    chk("t1_idle_push", buf_push, 0);
    chk("t1_idle_ready", req_ready, 0);
    tick();
    chk("t1_grant", grant, 4'b0100);
    chk("t1_busy", busy, 1);
    chk("t1_ready", req_ready, 4'b0100);
    chk("t1_push", buf_push, 1);
    chk("t1_din0", buf_din, 9'h0A0);
    tick();
    req_data[2*DW +: DW] = 8'hA1; #1;
    chk("t1_din1", buf_din, 9'h0A1);
    tick();
    req_data[2*DW +: DW] = 8'hA2; req_last[2] = 1'b1; #1;
    chk("t1_din2", buf_din, 9'h1A2);
    chk("t1_push2", buf_push, 1);
    tick();
    chk("t1_fdone", frame_done, 1);
    chk("t1_flen", frame_len, 3);
    chk("t1_grant_rel", grant, 0);
    chk("t1_busy_rel", busy, 0);
    req_valid = '0; req_last = '0; #1;
    chk("t1_idle_push2", buf_push, 0);
    tick();
    chk("t1_fdone_pulse", frame_done, 0);
    chk("t1_flen_hold", frame_len, 3);

    // round-robin, 1-beat frames from all requesters; rr_ptr starts at 3
    req_data = 32'h33221100; req_valid = 4'b1111; req_last = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_grant", grant, 32'd1 << rr_exp[i]);
      chk("rr_din", buf_din, 32'h100 | (rr_exp[i] * 32'h11));
      chk("rr_push", buf_push, 1);
      tick();
      chk("rr_gap_grant", grant, 0);
      chk("rr_fdone", frame_done, 1);
      chk("rr_flen", frame_len, 1);
      if (i == 4) begin
        req_valid = '0; req_last = '0;
      end
    end
    tick();
    chk("rr_idle_hold", grant, 0);

    // backpressure: afull high for 5 cycles mid-frame
    req_data[1*DW +: DW] = 8'hB0; req_valid = 4'b0010;
    tick();
    chk("bp_grant", grant, 4'b0010);
    chk("bp_push0", buf_push, 1);
    tick();
    buf_afull = 1'b1; #1;
    for (int j = 0; j < 5; j++) begin
      chk("bp_ready", req_ready, 0);
      chk("bp_push", buf_push, 0);
      tick();
      chk("bp_tmo", tmo_err, 0);
      chk("bp_busy", busy, 1);
    end
    buf_afull = 1'b0; req_data[1*DW +: DW] = 8'hB1; #1;
    chk("bp_push1", buf_push, 1);
    chk("bp_din1", buf_din, 9'h0B1);
    tick();
    req_data[1*DW +: DW] = 8'hB2; req_last[1] = 1'b1; #1;
    chk("bp_din2", buf_din, 9'h1B2);
    tick();
    chk("bp_fdone", frame_done, 1);
    chk("bp_flen", frame_len, 3);
    chk("bp_tmo_end", tmo_err, 0);
    req_valid = '0; req_last = '0;

    // timeout: owner 0 stops after 2 beats, requester 3 waiting
    req_data[0 +: DW] = 8'hC0; req_valid = 4'b0001;
    tick();
    chk("to_grant", grant, 4'b0001);
    tick();
    req_data[0 +: DW] = 8'hC1;
    tick();
    req_valid = 4'b1000; req_data[3*DW +: DW] = 8'hD0; req_last[3] = 1'b1; #1;
    chk("to_push_off", buf_push, 0);
    chk("to_ready", req_ready, 4'b0001);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("to_early", tmo_err, 0);
      chk("to_busy", busy, 1);
    end
    tick();
    chk("to_pulse", tmo_err, 1);
    chk("to_grant_rel", grant, 0);
    chk("to_flen", frame_len, 2);
    chk("to_no_fdone", frame_done, 0);
    tick();
    chk("to_next_grant", grant, 4'b1000);
    chk("to_next_din", buf_din, 9'h1D0);
    chk("to_tmo_clr", tmo_err, 0);
    tick();
    chk("to_next_fdone", frame_done, 1);
    chk("to_next_flen", frame_len, 1);
    req_valid = '0; req_last = '0;

    // isolation: requester 2 toggles valid/last during requester 0's frame
    req_data[0 +: DW] = 8'hE0; req_data[2*DW +: DW] = 8'h5A; req_valid = 4'b0101;
    tick();
    chk("iso_grant", grant, 4'b0001);
    chk("iso_din0", buf_din, 9'h0E0);
    chk("iso_ready0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0001; req_last = 4'b0100;
    req_data[2*DW +: DW] = 8'hA5; req_data[0 +: DW] = 8'hE1; #1;
    chk("iso_din1", buf_din, 9'h0E1);
    chk("iso_ready1", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0101; req_last = 4'b0101; req_data[0 +: DW] = 8'hE2; #1;
    chk("iso_din2", buf_din, 9'h1E2);
    chk("iso_ready2", req_ready, 4'b0001);
    tick();
    chk("iso_fdone", frame_done, 1);
    chk("iso_flen", frame_len, 3);
    req_valid = '0; req_last = '0;

    // reset during beat 2 of a 5-beat frame
    req_data[1*DW +: DW] = 8'hF0; req_valid = 4'b0010;
    tick();
    chk("rm_grant", grant, 4'b0010);
    tick();
    req_data[1*DW +: DW] = 8'hF1; #1;
    chk("rm_push_pre", buf_push, 1);
    rst = 1'b1; #1;
    chk("rm_grant0", grant, 0);
    chk("rm_busy0", busy, 0);
    chk("rm_push0", buf_push, 0);
    chk("rm_ready0", req_ready, 0);
    chk("rm_flen0", frame_len, 0);
    tick();
    chk("rm_fdone", frame_done, 0);
    chk("rm_tmo", tmo_err, 0);
    rst = 1'b0; req_valid = 4'b1111;
    tick();
    chk("rm_rearb", grant, 4'b0001);
    chk("rm_fdone2", frame_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
